// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rob_pkg
//  Brief   : Shared configuration and types for the reorder buffer.
//            ROB_SIZE / ROB_SIZE_BIT are the global configuration macros.
//            Everything else in the ROB derives its widths from them.
//  Revision: 1.0  initial release
// ============================================================================
`ifndef ROB_SIZE
`define ROB_SIZE 8
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 3
`endif

package rob_pkg;

    localparam int ROB_SIZE     = `ROB_SIZE;
    localparam int ROB_SIZE_BIT = `ROB_SIZE_BIT;
    localparam int XLEN         = 32;
    localparam int REG_W        = 5;

    // Entry index (tag) and occupancy counter; the counter needs one extra
    // bit so that "completely full" is distinguishable from "empty".
    typedef logic [ROB_SIZE_BIT-1:0] rob_tag_t;
    typedef logic [ROB_SIZE_BIT:0]   rob_cnt_t;

    localparam rob_cnt_t ROB_FULL  = rob_cnt_t'(ROB_SIZE);
    localparam rob_cnt_t ROB_EMPTY = '0;

    // Advance a circular pointer, wrapping explicitly so that sizes which
    // are not a power of two still behave.
    function automatic rob_tag_t tag_inc(input rob_tag_t t);
        if (int'(t) == ROB_SIZE - 1) begin
            return '0;
        end
        return t + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_if.sv
`default_nettype none
// ============================================================================
//  Module  : rob_if
//  Brief   : Bundle of every ROB-facing bus: decoder issue, CDB writeback,
//            register-file rename/commit updates, flush, operand query and
//            store-buffer commit notice.
//            master = core side (decoder / execution / RF), slave = ROB.
//  Revision: 1.0  initial release
// ============================================================================
interface rob_if;
    import rob_pkg::*;

    // decoder issue
    logic             issue_valid;
    logic [REG_W-1:0] issue_rd;
    logic             issue_has_rd;
    logic             issue_is_br;
    logic             issue_pred_taken;
    logic [XLEN-1:0]  issue_alt_pc;
    logic             issue_ready;
    rob_tag_t         issue_tag;

    // execution writeback
    logic             cdb_valid;
    rob_tag_t         cdb_tag;
    logic [XLEN-1:0]  cdb_val;
    logic             cdb_br_taken;

    // rename update
    logic             rf_dep_we;
    logic [REG_W-1:0] rf_dep_id;
    rob_tag_t         rf_dep;

    // commit update
    logic             rf_val_we;
    logic [REG_W-1:0] rf_val_id;
    rob_tag_t         rf_val_dep;
    logic [XLEN-1:0]  rf_val;

    // flush
    logic             rob_clear;
    logic [XLEN-1:0]  clear_pc;

    // operand lookup
    rob_tag_t         qry1_tag;
    rob_tag_t         qry2_tag;
    logic             qry1_ready;
    logic             qry2_ready;
    logic [XLEN-1:0]  qry1_val;
    logic [XLEN-1:0]  qry2_val;

    // head retire notice
    logic             commit_valid;
    rob_tag_t         commit_tag;

    modport master (
        output issue_valid, issue_rd, issue_has_rd, issue_is_br,
               issue_pred_taken, issue_alt_pc,
        input  issue_ready, issue_tag,
        output cdb_valid, cdb_tag, cdb_val, cdb_br_taken,
        input  rf_dep_we, rf_dep_id, rf_dep,
        input  rf_val_we, rf_val_id, rf_val_dep, rf_val,
        input  rob_clear, clear_pc,
        output qry1_tag, qry2_tag,
        input  qry1_ready, qry2_ready, qry1_val, qry2_val,
        input  commit_valid, commit_tag
    );

    modport slave (
        input  issue_valid, issue_rd, issue_has_rd, issue_is_br,
               issue_pred_taken, issue_alt_pc,
        output issue_ready, issue_tag,
        input  cdb_valid, cdb_tag, cdb_val, cdb_br_taken,
        output rf_dep_we, rf_dep_id, rf_dep,
        output rf_val_we, rf_val_id, rf_val_dep, rf_val,
        output rob_clear, clear_pc,
        input  qry1_tag, qry2_tag,
        output qry1_ready, qry2_ready, qry1_val, qry2_val,
        output commit_valid, commit_tag
    );

endinterface

`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
//  Module  : rob
//  Brief   : Reorder buffer. Circular buffer of ROB_SIZE entries, in-order
//            issue at tail, out-of-order completion from the CDB, in-order
//            commit at head (one per cycle). A mispredicted branch commits
//            its value, then raises a one-cycle flush that empties the ROB
//            and redirects fetch to the branch's alternate PC.
//            rdy_in low freezes all state and silences every strobe.
//  Revision: 1.0  initial release
// ============================================================================
module rob
    import rob_pkg::*;
(
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic rdy_in,
    rob_if.slave      bus
);

    // ------------------------------------------------------------------
    // Pointers, occupancy and flush state
    // ------------------------------------------------------------------
    rob_tag_t        head;
    rob_tag_t        tail;
    rob_cnt_t        count;
    logic            clear_pend;
    logic [XLEN-1:0] clear_pc_q;

    // ------------------------------------------------------------------
    // Per-entry fields
    // ------------------------------------------------------------------
    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] has_rd;
    logic [ROB_SIZE-1:0] is_br;
    logic [ROB_SIZE-1:0] pred_taken;
    logic [ROB_SIZE-1:0] br_taken;
    logic [REG_W-1:0]    rd     [ROB_SIZE];
    logic [XLEN-1:0]     alt_pc [ROB_SIZE];
    logic [XLEN-1:0]     val    [ROB_SIZE];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic run;          // ROB may issue / commit this cycle
    logic issue_ok;
    logic issue_fire;
    logic commit_fire;
    logic cdb_hit;      // writeback addressed to a live entry
    logic mispredict;
    logic do_clear;     // flush takes effect at this edge
    logic qry1_byp;
    logic qry2_byp;

    assign run         = rdy_in & ~clear_pend;
    assign issue_ok    = run & (count != ROB_FULL);
    assign issue_fire  = bus.issue_valid & issue_ok;
    assign commit_fire = run & (count != ROB_EMPTY) & ready[head];
    assign cdb_hit     = rdy_in & bus.cdb_valid & busy[bus.cdb_tag];
    assign mispredict  = commit_fire & is_br[head]
                       & (br_taken[head] != pred_taken[head]);
    assign do_clear    = rdy_in & clear_pend;

    // Pointer, counter and flush-request register update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            clear_pend <= 1'b0;
            clear_pc_q <= '0;
        end else if (do_clear) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            clear_pend <= 1'b0;
        end else begin
            if (issue_fire) begin
                tail <= tag_inc(tail);
            end
            if (commit_fire) begin
                head <= tag_inc(head);
            end
            // Simultaneous issue and commit leave occupancy unchanged.
            case ({issue_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // The branch's own value still commits; younger work is
            // discarded by the flush on the following edge.
            if (mispredict) begin
                clear_pend <= 1'b1;
                clear_pc_q <= alt_pc[head];
            end
        end
    end

    // Entry allocation, writeback capture and retirement
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            ready      <= '0;
            has_rd     <= '0;
            is_br      <= '0;
            pred_taken <= '0;
            br_taken   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd[i]     <= '0;
                alt_pc[i] <= '0;
                val[i]    <= '0;
            end
        end else if (do_clear) begin
            busy  <= '0;
            ready <= '0;
        end else begin
            // Writeback to a free slot is stale (flushed producer): ignore.
            if (cdb_hit) begin
                val[bus.cdb_tag]      <= bus.cdb_val;
                br_taken[bus.cdb_tag] <= bus.cdb_br_taken;
                ready[bus.cdb_tag]    <= 1'b1;
            end
            if (commit_fire) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
            end
            // Tail is never busy when issue fires, so this cannot collide
            // with the writeback or retirement above.
            if (issue_fire) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= 1'b0;
                rd[tail]         <= bus.issue_rd;
                has_rd[tail]     <= bus.issue_has_rd;
                is_br[tail]      <= bus.issue_is_br;
                pred_taken[tail] <= bus.issue_pred_taken;
                alt_pc[tail]     <= bus.issue_alt_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue side and rename update (same cycle as the issue)
    // ------------------------------------------------------------------
    assign bus.issue_ready = issue_ok;
    assign bus.issue_tag   = tail;
    assign bus.rf_dep_we   = issue_fire & bus.issue_has_rd
                           & (bus.issue_rd != '0);
    assign bus.rf_dep_id   = bus.issue_rd;
    assign bus.rf_dep      = tail;

    // ------------------------------------------------------------------
    // Commit side: register-file value update and store-buffer notice.
    // x0 is never written back.
    // ------------------------------------------------------------------
    assign bus.rf_val_we    = commit_fire & has_rd[head] & (rd[head] != '0);
    assign bus.rf_val_id    = rd[head];
    assign bus.rf_val_dep   = head;
    assign bus.rf_val       = val[head];
    assign bus.commit_valid = commit_fire;
    assign bus.commit_tag   = head;

    // ------------------------------------------------------------------
    // Flush pulse; held off while the core is stalled
    // ------------------------------------------------------------------
    assign bus.rob_clear = do_clear;
    assign bus.clear_pc  = clear_pc_q;

    // ------------------------------------------------------------------
    // Operand lookup with same-cycle CDB bypass
    // ------------------------------------------------------------------
    assign qry1_byp       = bus.cdb_valid & (bus.cdb_tag == bus.qry1_tag);
    assign qry2_byp       = bus.cdb_valid & (bus.cdb_tag == bus.qry2_tag);
    assign bus.qry1_ready = ready[bus.qry1_tag] | qry1_byp;
    assign bus.qry2_ready = ready[bus.qry2_tag] | qry2_byp;
    assign bus.qry1_val   = qry1_byp ? bus.cdb_val : val[bus.qry1_tag];
    assign bus.qry2_val   = qry2_byp ? bus.cdb_val : val[bus.qry2_tag];

endmodule

`default_nettype wire

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 clk_in  in  1  system clock; all state updates on rising edge.
REQ-002 rst_in  in  1  reset, synchronous, active-high.
REQ-003 rdy_in  in  1  low freezes all state; every strobe output forced 0.
REQ-004 issue_valid / issue_rd[4:0] / issue_has_rd / issue_is_br / issue_pred_taken / issue_alt_pc[31:0]  in  decoder issue request; alt_pc is the PC to redirect to if the prediction is wrong.
REQ-005 issue_ready  out  1  ROB accepts an issue this cycle; issue_tag[`ROB_SIZE_BIT-1:0] out = tail index.
REQ-006 cdb_valid / cdb_tag[`ROB_SIZE_BIT-1:0] / cdb_val[31:0] / cdb_br_taken  in  execution writeback.
REQ-007 rf_dep_we / rf_dep_id[4:0] / rf_dep[`ROB_SIZE_BIT-1:0]  out  rename update to register file.
REQ-008 rf_val_we / rf_val_id[4:0] / rf_val_dep[`ROB_SIZE_BIT-1:0] / rf_val[31:0]  out  commit update to register file.
REQ-009 rob_clear  out  1  flush pulse to RF and all consumers; clear_pc[31:0] out = redirect PC.
REQ-010 qry1_tag, qry2_tag  in  `ROB_SIZE_BIT; qryN_ready out 1, qryN_val out 32  operand lookup.
REQ-011 commit_valid out 1, commit_tag out `ROB_SIZE_BIT  head retire notice for store buffer.

Function
REQ-012 Circular buffer of `ROB_SIZE entries; head, tail, count registers; per entry: busy, ready, rd, has_rd, is_br, pred_taken, alt_pc, val, br_taken.
REQ-013 issue_ready = rdy_in & ~clear_pend & (count != `ROB_SIZE); issue fires when issue_valid & issue_ready.
REQ-014 On issue fire: entry[tail] written busy=1 ready=0; tail <= tail+1 mod `ROB_SIZE (wraps 7->0 at size 8).
REQ-015 rf_dep_we combinational = issue fire & issue_has_rd & (issue_rd != 0); rf_dep_id = issue_rd; rf_dep = tail.
REQ-016 On cdb_valid with busy target: entry.val, entry.br_taken latched, ready=1 at that edge; cdb to non-busy entry ignored.
REQ-017 Commit fires combinationally when rdy_in & ~clear_pend & count!=0 & entry[head].ready; one commit per cycle max.
REQ-018 On commit: rf_val_we = has_rd & rd!=0; rf_val_id=rd; rf_val_dep=head; rf_val=val; commit_valid=1; commit_tag=head; head advances mod size; entry busy cleared.
REQ-019 Mispredict = committing entry is_br & (br_taken != pred_taken); value still committed; clear_pend <= 1, clear_pc latched <= alt_pc.
REQ-020 rob_clear = clear_pend (registered, exactly one cycle); at that edge head=tail=count=0, all busy=0, clear_pend<=0; no issue or commit while clear_pend.
REQ-021 Simultaneous issue and commit: count unchanged; full ROB blocks issue even if head commits same cycle.
REQ-022 qryN_ready = entry ready, or cdb_valid & cdb_tag==qryN_tag (bypass, qryN_val=cdb_val); else qryN_val = entry.val.
REQ-023 Latency: issue->rename update same cycle; cdb->earliest commit next cycle; mispredict commit->rob_clear next cycle.

Reset
REQ-024 rst_in at edge: head=tail=count=0, all busy/ready=0, clear_pend=0, clear_pc=0.
REQ-025 Outputs after reset: issue_ready=1 (when rdy_in), issue_tag=0, all we/valid strobes=0, rob_clear=0, qry outputs reflect cleared entries.
REQ-026 Reset mid-flush or with outstanding entries discards all state; reset overrides rdy_in.

Structure
REQ-027 `ROB_SIZE (8) and `ROB_SIZE_BIT (3) live in the shared Config header; no local redefinition.
REQ-028 Single module, no sub-modules; entry fields held as register arrays.

Verification
REQ-029 Issue rd=5 with tag 0, cdb tag0 val=0x1234 -> next cycle rf_val_we=1, id=5, dep=0, val=0x1234; rf_dep_we=1 at issue cycle.
REQ-030 Issue 8 entries, no cdb -> issue_ready=0 after 8th; 9th request stalls; after commit of tag0, tail wraps to 0 on next issue.
REQ-031 Branch pred_taken=0 alt_pc=0x100 at tag2, cdb br_taken=1 -> commit tag2, next cycle rob_clear=1 clear_pc=0x100, then count=0, issue_tag=0.
REQ-032 cdb tag3 val=0xAB same cycle qry1_tag=3 -> qry1_ready=1, qry1_val=0xAB combinationally.
REQ-033 Issue rd=0 -> rf_dep_we=0; its commit -> rf_val_we=0, commit_valid=1.
REQ-034 rdy_in low for 3 cycles with ready head -> no commit, no state change; commit occurs first cycle rdy_in returns.
